sound_mixer_dac: RTL and testbench

Downstream consumer of the cartridge sound outputs (megarom SCC/IKASCC and future sound cartridges).
- Snapshots every source on a sample strobe.
- Applies a per-channel 4-bit volume and sums the channels time-multiplexed through one multiplier.
- Saturates the sum to the PCM width.
- Drives a first-order delta-sigma 1-bit DAC pin running at full CLK rate.

---
 rtl/sound_pkg.sv | 32 +++
 rtl/sound_dsdac.sv | 33 +++
 rtl/sound_mixer_dac.sv | 165 ++++++++++++++++
 tb/tb_sound_mixer_dac.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/sound_pkg.sv
// Shared types and helpers for the sound mixer and its DAC back end.
package sound_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    SAT,
    HPF
  } state_t;

  // Volume code 8 is unity gain, so products are scaled down by 2^3.
  localparam int VOL_SHIFT = 3;
  // DC-blocker pole sits at 1 - 2^-8.
  localparam int HPF_SHIFT = 8;
  localparam int SAT_W     = 64;

  // Clamp a sign-extended value to the signed range of 'width' bits.
  // The caller truncates the result to 'width'.
  function automatic logic signed [SAT_W-1:0] saturate(
    input logic signed [SAT_W-1:0] x,
    input int                      width
  );
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (x > hi)      return hi;
    else if (x < lo) return lo;
    else             return x;
  endfunction

endpackage

// File: rtl/sound_dsdac.sv
// First-order delta-sigma 1-bit DAC. The PCM word is converted to
// offset binary and accumulated every clock; the carry out is the bit.
module sound_dsdac #(
  parameter int OUT_BITS = 16
) (
  input  logic                RESET_n,
  input  logic                CLK,
  input  logic [OUT_BITS-1:0] PCM,
  output logic                DAC_OUT
);

  logic [OUT_BITS-1:0] u;
  logic [OUT_BITS-1:0] integ;
  logic [OUT_BITS:0]   sum;

  // Offset-binary input and integrator sum with carry.
  always_comb begin
    u   = {~PCM[OUT_BITS-1], PCM[OUT_BITS-2:0]};
    sum = {1'b0, integ} + {1'b0, u};
  end

  // Integrator state and registered carry.
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      integ   <= '0;
      DAC_OUT <= 1'b0;
    end else begin
      integ   <= sum[OUT_BITS-1:0];
      DAC_OUT <= sum[OUT_BITS];
    end
  end

endmodule

// File: rtl/sound_mixer_dac.sv
// Cartridge sound mixer: snapshot on SAMPLE_EN, per-channel volume via a
// single shared multiplier, saturate to PCM, then a delta-sigma DAC.
// Build option SOUND_DCCUT_EN inserts a DC-blocking stage after saturation.
//
// state | meaning
// IDLE  | waiting for SAMPLE_EN
// MAC   | one channel multiply-accumulate per cycle
// SAT   | clamp / mute, publish result (or hand to HPF)
// HPF   | DC blocker, publish result (SOUND_DCCUT_EN only)
module sound_mixer_dac
  import sound_pkg::*;
#(
  parameter int CH_COUNT = 2,
  parameter int IN_BITS  = 16,
  parameter int VOL_BITS = 4,
  parameter int OUT_BITS = 16
) (
  input  logic                         RESET_n,
  input  logic                         CLK,
  input  logic                         SAMPLE_EN,
  input  logic [CH_COUNT*IN_BITS-1:0]  IN_SIG,
  input  logic [CH_COUNT*VOL_BITS-1:0] IN_VOL,
  input  logic                         MUTE,
  output logic [OUT_BITS-1:0]          PCM_OUT,
  output logic                         PCM_VALID,
  output logic                         OVERRUN,
  output logic                         DAC_OUT
);

  localparam int PROD_W = IN_BITS + VOL_BITS + 1;
  localparam int ACC_W  = IN_BITS + VOL_BITS + $clog2(CH_COUNT) + 1;
  localparam int CH_W   = (CH_COUNT > 1) ? $clog2(CH_COUNT) : 1;

  state_t                         state;
  state_t                         state_nx;
  logic [CH_W-1:0]                ch;
  logic signed [ACC_W-1:0]        acc;
  logic [CH_COUNT*IN_BITS-1:0]    sig_snap;
  logic [CH_COUNT*VOL_BITS-1:0]   vol_snap;
  logic                           mute_snap;
  logic signed [IN_BITS-1:0]      sig_cur;
  logic [VOL_BITS-1:0]            vol_cur;
  logic signed [PROD_W-1:0]       prod;
  logic signed [PROD_W-1:0]       term;
  logic                           last_ch;
  logic [OUT_BITS-1:0]            mixed;

  // Current channel product, scaled so volume 8 is unity.
  always_comb begin
    sig_cur = sig_snap[int'(ch)*IN_BITS +: IN_BITS];
    vol_cur = vol_snap[int'(ch)*VOL_BITS +: VOL_BITS];
    prod    = PROD_W'(sig_cur) * PROD_W'($signed({1'b0, vol_cur}));
    term    = prod >>> VOL_SHIFT;
    last_ch = (ch == CH_W'(CH_COUNT - 1));
  end

  // Saturated (or muted) mix result.
  always_comb begin
    mixed = OUT_BITS'(saturate(SAT_W'(acc), OUT_BITS));
    if (mute_snap) mixed = '0;
  end

`ifdef SOUND_DCCUT_EN
  localparam int HPF_W = OUT_BITS + 3;

  logic signed [OUT_BITS-1:0] x_cur;
  logic signed [OUT_BITS-1:0] x_prev;
  logic signed [OUT_BITS-1:0] y_prev;
  logic signed [HPF_W-1:0]    hpf_sum;
  logic [OUT_BITS-1:0]        hpf_y;

  // DC blocker: y = x - x_prev + y_prev - y_prev/256, clamped.
  always_comb begin
    hpf_sum = HPF_W'(x_cur) - HPF_W'(x_prev) + HPF_W'(y_prev)
              - HPF_W'(y_prev >>> HPF_SHIFT);
    hpf_y   = OUT_BITS'(saturate(SAT_W'(hpf_sum), OUT_BITS));
  end
`endif

  // State register.
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) state <= IDLE;
    else          state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (SAMPLE_EN) state_nx = MAC;
      MAC:  if (last_ch)   state_nx = SAT;
`ifdef SOUND_DCCUT_EN
      SAT:  state_nx = HPF;
`else
      SAT:  state_nx = IDLE;
`endif
      HPF:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: snapshot, accumulate, publish; strobes while busy are dropped.
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      ch        <= '0;
      acc       <= '0;
      sig_snap  <= '0;
      vol_snap  <= '0;
      mute_snap <= 1'b0;
      PCM_OUT   <= '0;
      PCM_VALID <= 1'b0;
      OVERRUN   <= 1'b0;
`ifdef SOUND_DCCUT_EN
      x_cur     <= '0;
      x_prev    <= '0;
      y_prev    <= '0;
`endif
    end else begin
      PCM_VALID <= 1'b0;
      if (SAMPLE_EN && state != IDLE) OVERRUN <= 1'b1;
      case (state)
        IDLE: begin
          if (SAMPLE_EN) begin
            sig_snap  <= IN_SIG;
            vol_snap  <= IN_VOL;
            mute_snap <= MUTE;
            acc       <= '0;
            ch        <= '0;
          end
        end
        MAC: begin
          acc <= acc + ACC_W'(term);
          ch  <= last_ch ? '0 : ch + CH_W'(1);
        end
        SAT: begin
`ifdef SOUND_DCCUT_EN
          x_cur     <= mixed;
`else
          PCM_OUT   <= mixed;
          PCM_VALID <= 1'b1;
`endif
        end
        HPF: begin
`ifdef SOUND_DCCUT_EN
          PCM_OUT   <= hpf_y;
          PCM_VALID <= 1'b1;
          x_prev    <= x_cur;
          y_prev    <= hpf_y;
`endif
        end
        default: ;
      endcase
    end
  end

  sound_dsdac #(
    .OUT_BITS (OUT_BITS)
  ) u_dsdac (
    .RESET_n (RESET_n),
    .CLK     (CLK),
    .PCM     (PCM_OUT),
    .DAC_OUT (DAC_OUT)
  );

endmodule

// File: tb/tb_sound_mixer_dac.sv
// Directed bench for sound_mixer_dac (CH_COUNT=2, 16-bit samples).
module tb_sound_mixer_dac;

  localparam int CH = 2;
  localparam int IB = 16;
  localparam int VB = 4;
  localparam int OB = 16;
`ifdef SOUND_DCCUT_EN
  localparam int LAT = CH + 3;
`else
  localparam int LAT = CH + 2;
`endif

  logic              RESET_n;
  logic              CLK;
  logic              SAMPLE_EN;
  logic [CH*IB-1:0]  IN_SIG;
  logic [CH*VB-1:0]  IN_VOL;
  logic              MUTE;
  logic [OB-1:0]     PCM_OUT;
  logic              PCM_VALID;
  logic              OVERRUN;
  logic              DAC_OUT;

  int n_vec = 0;
  int n_bad = 0;

  sound_mixer_dac #(
    .CH_COUNT (CH),
    .IN_BITS  (IB),
    .VOL_BITS (VB),
    .OUT_BITS (OB)
  ) dut (
    .RESET_n   (RESET_n),
    .CLK       (CLK),
    .SAMPLE_EN (SAMPLE_EN),
    .IN_SIG    (IN_SIG),
    .IN_VOL    (IN_VOL),
    .MUTE      (MUTE),
    .PCM_OUT   (PCM_OUT),
    .PCM_VALID (PCM_VALID),
    .OVERRUN   (OVERRUN),
    .DAC_OUT   (DAC_OUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Strobe one sample and wait (bounded) for PCM_VALID; lat counts edges
  // from the capturing edge. scramble disturbs inputs right after capture.
  task automatic mix(input logic [15:0] s0, input logic [15:0] s1,
                     input logic [3:0] v0, input logic [3:0] v1,
                     input logic m, input logic scramble, output int lat);
    IN_SIG    = {s1, s0};
    IN_VOL    = {v1, v0};
    MUTE      = m;
    SAMPLE_EN = 1'b1;
    lat       = 0;
    while (lat < 20) begin
      tick();
      lat++;
      if (lat == 1) begin
        SAMPLE_EN = 1'b0;
        if (scramble) begin
          IN_SIG = ~IN_SIG;
          IN_VOL = 8'h00;
          MUTE   = ~MUTE;
        end
      end
      if (PCM_VALID) break;
    end
  endtask

  task automatic do_mix(input string tag, input logic [15:0] s0, input logic [15:0] s1,
                        input logic [3:0] v0, input logic [3:0] v1,
                        input logic m, input logic scramble, input logic [15:0] exp_pcm);
    int lat;
    mix(s0, s1, v0, v1, m, scramble, lat);
    chk({tag, "_lat"}, lat, LAT);
    chk({tag, "_pcm"}, PCM_OUT, exp_pcm);
  endtask

  task automatic count_dac(input int n, output int ones);
    ones = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      ones += int'(DAC_OUT);
    end
  endtask

  initial begin
    int ones;
    int nval;
    int lat;
    RESET_n   = 1'b0;
    SAMPLE_EN = 1'b0;
    IN_SIG    = '0;
    IN_VOL    = '0;
    MUTE      = 1'b0;
    #22;
    chk("rst_pcm",   PCM_OUT,   0);
    chk("rst_valid", PCM_VALID, 0);
    chk("rst_ovr",   OVERRUN,   0);
    chk("rst_dac",   DAC_OUT,   0);
    RESET_n = 1'b1;
    tick();
    tick();

`ifdef SOUND_DCCUT_EN
    // First sample passes straight through the blocker; a held level then
    // bleeds away until the truncating shift leaves less than 2^8.
    do_mix("hpf_first", 16'd1000, 16'd0, 4'd8, 4'd0, 1'b0, 1'b0, 16'd1000);
    for (int i = 0; i < 2047; i++) mix(16'd1000, 16'd0, 4'd8, 4'd0, 1'b0, 1'b0, lat);
    chk("hpf_decay", ($signed(PCM_OUT) >= 0) && ($signed(PCM_OUT) < 256), 1);
`else
    // 1000*8/8 + (-200*4)/8 = 1000 - 100
    do_mix("basic", 16'd1000, 16'hFF38, 4'd8, 4'd4, 1'b0, 1'b0, 16'd900);
    tick();
    chk("valid_pulse", PCM_VALID, 0);
    do_mix("sat_pos", 16'h7FFF, 16'h7FFF, 4'd15, 4'd15, 1'b0, 1'b0, 16'h7FFF);
    do_mix("sat_neg", 16'h8000, 16'h8000, 4'd15, 4'd15, 1'b0, 1'b0, 16'h8000);
    do_mix("vol0",    16'd12345, 16'd8, 4'd0, 4'd8, 1'b0, 1'b0, 16'd8);
    // -3*1 >>> 3 rounds toward minus infinity
    do_mix("floor",   16'hFFFD, 16'd0, 4'd1, 4'd0, 1'b0, 1'b0, 16'hFFFF);
    do_mix("mute",    16'd1000, 16'd777, 4'd8, 4'd8, 1'b1, 1'b0, 16'd0);
    do_mix("scramble", 16'd1000, 16'hFF38, 4'd8, 4'd4, 1'b0, 1'b1, 16'd900);
    chk("ovr_clear", OVERRUN, 0);

    // Second strobe two cycles after the first is dropped.
    IN_SIG = {16'hFF38, 16'd1000};
    IN_VOL = {4'd4, 4'd8};
    MUTE = 1'b0;
    SAMPLE_EN = 1'b1;
    tick();
    SAMPLE_EN = 1'b0;
    tick();
    IN_SIG = {16'd0, 16'h7FFF};
    SAMPLE_EN = 1'b1;
    tick();
    SAMPLE_EN = 1'b0;
    tick();
    chk("ovr_valid", PCM_VALID, 1);
    chk("ovr_pcm",   PCM_OUT,   16'd900);
    chk("ovr_flag",  OVERRUN,   1);
    nval = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      nval += int'(PCM_VALID);
    end
    chk("ovr_dropped", nval, 0);
    do_mix("after_ovr", 16'd8, 16'd0, 4'd8, 4'd0, 1'b0, 1'b0, 16'd8);
    chk("ovr_sticky", OVERRUN, 1);

    // Delta-sigma density: 0x4000 -> u=0xC000 -> 3/4 ones.
    do_mix("dac_q", 16'h4000, 16'd0, 4'd8, 4'd0, 1'b0, 1'b0, 16'h4000);
    tick();
    tick();
    count_dac(1024, ones);
    chk("dac_4000", (ones >= 767) && (ones <= 769), 1);
    do_mix("dac_min", 16'h8000, 16'd0, 4'd8, 4'd0, 1'b0, 1'b0, 16'h8000);
    tick();
    tick();
    count_dac(1024, ones);
    chk("dac_8000", ones, 0);

    // Reset in the middle of a mix.
    do_mix("pre_rst", 16'd1000, 16'hFF38, 4'd8, 4'd4, 1'b0, 1'b0, 16'd900);
    IN_SIG = {16'd0, 16'd5000};
    IN_VOL = {4'd0, 4'd8};
    SAMPLE_EN = 1'b1;
    tick();
    SAMPLE_EN = 1'b0;
    tick();
    RESET_n = 1'b0;
    #1;
    chk("mid_rst_pcm",   PCM_OUT,   0);
    chk("mid_rst_valid", PCM_VALID, 0);
    chk("mid_rst_ovr",   OVERRUN,   0);
    chk("mid_rst_dac",   DAC_OUT,   0);
    tick();
    RESET_n = 1'b1;
    tick();
    nval = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      nval += int'(PCM_VALID);
    end
    chk("rst_discard", nval, 0);
    do_mix("post_rst", 16'd1000, 16'd0, 4'd8, 4'd0, 1'b0, 1'b0, 16'd1000);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
